// File: rtl/mmio_timer_pkg.sv
// rtl/mmio_timer_pkg.sv - shared state encoding, register offsets and CTRL field positions
package mmio_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] CTRL_OFF   = 2'd0;
  localparam logic [1:0] PRESET_OFF = 2'd1;
  localparam logic [1:0] COUNT_OFF  = 2'd2;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

endpackage

// File: rtl/mmio_timer_if.sv
// rtl/mmio_timer_if.sv - CPU data-memory load/store port as seen by the timer
interface mmio_timer_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, output we, output wdata, input rdata, input irq);
  modport slave  (input addr, input we, input wdata, output rdata, output irq);
endinterface

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped countdown timer with one-shot/auto-reload modes and masked irq
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input logic         clk,
  input logic         reset,
  mmio_timer_if.slave bus
);

  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  state_t      state, state_nxt;

  logic       sel;
  logic [1:0] off;
  logic       wr_ctrl, wr_preset;
  logic       en, reload_mode;
  logic       do_load, do_dec, set_flag, clr_flag, clr_en;

  assign sel         = (bus.addr[31:4] == BASE[31:4]);
  assign off         = bus.addr[3:2];
  assign wr_ctrl     = sel & bus.we & (off == CTRL_OFF);
  assign wr_preset   = sel & bus.we & (off == PRESET_OFF);
  assign en          = ctrl[CTRL_EN];
  assign reload_mode = (ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_dec    = 1'b0;
    set_flag  = 1'b0;
    clr_flag  = 1'b0;
    clr_en    = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = LOAD;
      LOAD: begin
        do_load   = 1'b1;
        state_nxt = CNT;
      end
      CNT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (count != 32'd0) begin
          do_dec = 1'b1;
        end else begin
          set_flag  = 1'b1;
          state_nxt = INT;
        end
      end
      INT: begin
        if (reload_mode) begin
          clr_flag  = 1'b1;
          state_nxt = LOAD;
        end else begin
          clr_en    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A CPU write to CTRL overrides any same-cycle FSM update of EN or irq_flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= 4'd0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      if (do_load)     count <= preset;
      else if (do_dec) count <= count - 32'd1;

      if (wr_preset) preset <= bus.wdata;

      if (wr_ctrl) begin
        ctrl     <= bus.wdata[3:0];
        irq_flag <= 1'b0;
      end else begin
        if (clr_en)        ctrl[CTRL_EN] <= 1'b0;
        if (set_flag)      irq_flag <= 1'b1;
        else if (clr_flag) irq_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    if (sel) begin
      case (off)
        CTRL_OFF:   bus.rdata = {28'd0, ctrl};
        PRESET_OFF: bus.rdata = preset;
        COUNT_OFF:  bus.rdata = count;
        default:    bus.rdata = 32'd0;
      endcase
    end
  end

  assign bus.irq = irq_flag & ctrl[CTRL_IM];

endmodule

// File: tb/tb_mmio_timer.sv
// tb/tb_mmio_timer.sv - directed self-checking bench for mmio_timer
module tb_mmio_timer;

  localparam logic [31:0] BASE     = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL   = BASE;
  localparam logic [31:0] A_PRESET = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_RSV    = BASE + 32'hC;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] d;

  mmio_timer_if bus ();

  mmio_timer #(.BASE(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    bus.addr  = a;
    bus.wdata = v;
    bus.we    = 1'b1;
    @(posedge clk);
    #1;
    bus.we    = 1'b0;
    bus.addr  = 32'd0;
    bus.wdata = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.addr = a;
    #1;
    v = bus.rdata;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 32'(4 * i), d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL reset_read off=%0d: got %h expected %h", 4 * i, d, 32'd0);
      end
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b expected 0", bus.irq);
    end
    wr(BASE + 32'h20, 32'd5);
    wr(BASE + 32'h24, 32'd5);
    tick(3);
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 32'(4 * i), d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL outside_write off=%0d: got %h expected %h", 4 * i, d, 32'd0);
      end
    end
    rd(BASE + 32'h20, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL outside_read: got %h expected %h", d, 32'd0);
    end
  endtask

  task automatic test_oneshot;
    logic [31:0] exp_cnt;
    logic        exp_irq;
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'h9);
    for (int k = 1; k <= 9; k++) begin
      exp_cnt = (k >= 3 && k <= 6) ? 32'(6 - k) : 32'd0;
      exp_irq = (k >= 7);
      rd(A_COUNT, d);
      checks++;
      if (d !== exp_cnt) begin
        errors++;
        $display("FAIL oneshot_count cycle=%0d: got %0d expected %0d", k, d, exp_cnt);
      end
      checks++;
      if (bus.irq !== exp_irq) begin
        errors++;
        $display("FAIL oneshot_irq cycle=%0d: got %b expected %b", k, bus.irq, exp_irq);
      end
      tick(1);
    end
    rd(A_CTRL, d);
    checks++;
    if (d !== 32'h8) begin
      errors++;
      $display("FAIL oneshot_ctrl_after_int: got %h expected %h", d, 32'h8);
    end
    wr(A_CTRL, 32'h8);
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_irq_clear: got %b expected 0", bus.irq);
    end
  endtask

  task automatic test_autoreload;
    logic [31:0] exp_cnt;
    logic        exp_irq;
    int          p;
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 17; k++) begin
      p       = (k >= 3) ? (k - 3) % 5 : 0;
      exp_cnt = (k < 3) ? 32'd0 : ((p < 3) ? 32'(2 - p) : 32'd0);
      exp_irq = (k >= 6) && (((k - 6) % 5) == 0);
      rd(A_COUNT, d);
      checks++;
      if (d !== exp_cnt) begin
        errors++;
        $display("FAIL reload_count cycle=%0d: got %0d expected %0d", k, d, exp_cnt);
      end
      checks++;
      if (bus.irq !== exp_irq) begin
        errors++;
        $display("FAIL reload_irq cycle=%0d: got %b expected %b", k, bus.irq, exp_irq);
      end
      tick(1);
    end
    wr(A_CTRL, 32'h0);
    tick(3);
  endtask

  task automatic test_preset_zero;
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'h9);
    for (int k = 1; k <= 5; k++) begin
      if (k == 3) begin
        rd(A_COUNT, d);
        checks++;
        if (d !== 32'd0) begin
          errors++;
          $display("FAIL zero_count: got %0d expected 0", d);
        end
      end
      checks++;
      if (bus.irq !== (k >= 4)) begin
        errors++;
        $display("FAIL zero_irq cycle=%0d: got %b expected %b", k, bus.irq, (k >= 4));
      end
      tick(1);
    end
    rd(A_CTRL, d);
    checks++;
    if (d !== 32'h8) begin
      errors++;
      $display("FAIL zero_ctrl: got %h expected %h", d, 32'h8);
    end
    wr(A_CTRL, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (bus.irq !== 1'b0) begin
        errors++;
        $display("FAIL masked_irq cycle=%0d: got %b expected 0", k, bus.irq);
      end
      tick(1);
    end
    rd(A_CTRL, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL masked_en_clear: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_midcount;
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    tick(6);
    rd(A_COUNT, d);
    checks++;
    if (d !== 32'd6) begin
      errors++;
      $display("FAIL mid_count_before: got %0d expected 6", d);
    end
    wr(A_CTRL, 32'h0);
    for (int k = 0; k < 5; k++) begin
      rd(A_COUNT, d);
      checks++;
      if (d !== 32'd5) begin
        errors++;
        $display("FAIL mid_freeze step=%0d: got %0d expected 5", k, d);
      end
      checks++;
      if (bus.irq !== 1'b0) begin
        errors++;
        $display("FAIL mid_irq step=%0d: got %b expected 0", k, bus.irq);
      end
      tick(1);
    end
    wr(A_PRESET, 32'd4);
    wr(A_CTRL, 32'h1);
    tick(2);
    rd(A_COUNT, d);
    checks++;
    if (d !== 32'd4) begin
      errors++;
      $display("FAIL mid_restart: got %0d expected 4", d);
    end
    tick(1);
    rd(A_COUNT, d);
    checks++;
    if (d !== 32'd3) begin
      errors++;
      $display("FAIL mid_restart_dec: got %0d expected 3", d);
    end
    wr(A_CTRL, 32'h0);
    tick(3);
  endtask

  task automatic test_back_to_back;
    wr(A_PRESET, 32'd1);
    wr(A_CTRL, 32'h9);
    tick(4);
    wr(A_CTRL, 32'hB);
    rd(A_CTRL, d);
    checks++;
    if (d !== 32'hB) begin
      errors++;
      $display("FAIL int_write_wins: got %h expected %h", d, 32'hB);
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL int_write_irq: got %b expected 0", bus.irq);
    end
    tick(2);
    rd(A_COUNT, d);
    checks++;
    if (d !== 32'd1) begin
      errors++;
      $display("FAIL b2b_reload_count: got %0d expected 1", d);
    end
    wr(A_PRESET, 32'd3);
    rd(A_COUNT, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL preset_during_cnt: got %0d expected 0", d);
    end
    tick(1);
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL b2b_irq: got %b expected 1", bus.irq);
    end
    tick(2);
    rd(A_COUNT, d);
    checks++;
    if (d !== 32'd3) begin
      errors++;
      $display("FAIL new_preset_loaded: got %0d expected 3", d);
    end
    wr(A_CTRL, 32'h0);
    tick(3);
  endtask

  task automatic test_reset_mid;
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'h9);
    tick(4);
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL prereset_irq: got %b expected 1", bus.irq);
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL postreset_irq: got %b expected 0", bus.irq);
    end
    wr(A_PRESET, 32'd20);
    wr(A_CTRL, 32'hF);
    tick(15);
    rd(A_COUNT, d);
    checks++;
    if (d !== 32'd7) begin
      errors++;
      $display("FAIL prereset_count: got %0d expected 7", d);
    end
    reset     = 1'b1;
    bus.addr  = A_CTRL;
    bus.wdata = 32'hF;
    bus.we    = 1'b1;
    tick(1);
    reset     = 1'b0;
    bus.we    = 1'b0;
    bus.wdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 32'(4 * i), d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL midreset_read off=%0d: got %h expected %h", 4 * i, d, 32'd0);
      end
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL midreset_irq: got %b expected 0", bus.irq);
    end
    tick(4);
    rd(A_COUNT, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL midreset_idle_count: got %0d expected 0", d);
    end
    rd(A_RSV, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL reserved_read: got %h expected %h", d, 32'd0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.addr  = 32'd0;
    bus.we    = 1'b0;
    bus.wdata = 32'd0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_preset_zero();
    test_midcount();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped countdown timer that acts as the responder for the CPU's data-memory load/store interface. It is the other end of the datapath's MemAddr/MemData/MemWrite path.
- The CPU programs it with sw and reads it with lw in the address window selected by BASE.
- It counts down each clock and raises an interrupt request when the count expires.
- It sits beside DM in the top level; the system bridge muxes its rdata onto load results.

Parameters:
BASE, 32'h0000_7F00, word-aligned base address of the 16-byte register window; only BASE[31:4] is compared.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
addr  input  32  byte address from CPU (ALU result); addr[1:0] ignored.
we  input  1  store strobe; acts only when addr selects this block.
wdata  input  32  store data (GRF rt value).
rdata  output  32  combinational read data for the addressed register.
irq  output  1  interrupt request to CPU.

Behaviour:
- Select: sel = (addr[31:4] == BASE[31:4]). Offsets: 0x0 CTRL, 0x4 PRESET, 0x8 COUNT, 0xC reserved.
- CTRL fields: [0] EN enable, [2:1] MODE (00 one-shot, 01 auto-reload, 10/11 behave as 00), [3] IM interrupt mask. Bits [31:4] read 0.
- Writes (sel & we, posedge clk):
  - CTRL <= wdata[3:0], and irq_flag is cleared.
  - PRESET <= wdata.
  - Writes to COUNT and 0xC are ignored.
- Reads: rdata = CTRL (zero-extended) / PRESET / COUNT by offset. Offset 0xC, or sel=0, returns 32'h0. Reads have no side effects.
- Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. This makes rdata=0 and irq=0 on the first cycle after reset.
- irq = irq_flag & CTRL.IM (combinational from registers).
- FSM states: IDLE, LOAD, CNT, INT. One transition per clock.
  - IDLE: if EN -> LOAD, else stay.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT: if !EN -> IDLE (COUNT holds its value). Else if COUNT != 0: COUNT <= COUNT-1, stay. Else (COUNT == 0): irq_flag <= 1, -> INT.
  - INT, MODE==01: irq_flag <= 0 (one-cycle pulse), -> LOAD.
  - INT, other modes: CTRL.EN <= 0, -> IDLE. irq_flag holds until the next CTRL write or reset.
- Latency: with EN written in cycle 0 and PRESET=N:
  - COUNT reads N in cycle 3, then N-1, ... 0 in cycle N+3.
  - irq is high from cycle N+4 (if IM).
- Simultaneous events:
  - A CPU CTRL write in the same cycle as the FSM clearing EN in INT: the CPU write wins.
  - A PRESET write during CNT does not affect the running count; it takes effect at the next LOAD.
  - An EN=0 write takes effect in the next cycle's state decision: the FSM returns to IDLE and COUNT freezes.
- Boundaries:
  - PRESET=0: LOAD loads 0, CNT expires immediately, so irq rises two cycles after LOAD.
  - PRESET=32'hFFFF_FFFF counts without wrap. COUNT never decrements below 0.
- Reset mid-count: everything returns to reset values on that edge, irq drops in the next cycle, and any pending write in that cycle is discarded.
- The block does not care about byte-lane/sub-word stores; any store to the window is treated as a full-word write.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, LOAD=2'd1, CNT=2'd2, INT=2'd3), offset constants (CTRL_OFF=2'd0, PRESET_OFF=2'd1, COUNT_OFF=2'd2), and CTRL bit positions (EN=0, MODE=2:1, IM=3).
- Single flat module: register write decode, FSM and read mux together stay under ~200 lines, so no sub-module is warranted.

Test Plan:
- Reset, then read all four offsets at BASE -> rdata=0 each. Drive addr=BASE+0x20 with we=1, wdata=5 -> no register changes, rdata=0.
- PRESET=3, CTRL=0x9 (EN, mode 0, IM) written in cycle 0 -> COUNT reads 3,2,1,0 in cycles 3-6; irq=1 from cycle 7 and stays. CTRL reads 0x8 after INT. Write CTRL=0x8 -> irq=0 next cycle.
- PRESET=2, CTRL=0xB (auto-reload, IM) -> irq is a one-cycle pulse every 5 cycles (INT, LOAD, CNT 2,1,0). The period is repeatable over 3 periods.
- PRESET=0, CTRL=0x9 -> COUNT=0 in cycle 3, irq=1 in cycle 4. With CTRL=0x1 (IM=0) -> irq stays 0, but the FSM still clears EN.
- Mid-count: PRESET=10, enable, at COUNT=6 write CTRL=0x0 -> COUNT freezes at 5 or 6 per the next-cycle rule, state IDLE, no irq. Rewriting PRESET=4 then EN -> count restarts from 4.
- Assert reset while COUNT=7 with irq_flag set from a prior shot -> next cycle all reads 0 and irq=0. Simultaneous reset + CTRL write leaves CTRL=0.
